config_chain_sequencer: RTL
===========================

CONFIG_CHAIN_SEQUENCER -- requirements
Module: config_chain_sequencer

Interface
REQ-001 SHALL have parameter CHAIN_LEN, default 1024: total configuration bits in the FPGA shift chain (multiple of 1 to 2^16).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h3000_0000: Wishbone base; block decodes wbs_adr_i[31:4] == BASE_ADDR[31:4].
REQ-003 SHALL have parameter LATCH_CYCLES, default 2: width of the latch-enable pulse in clocks (1 to 15).
REQ-004 SHALL have one clock; reset is synchronous and active-high; ports are wb_clk_i and wb_rst_i.
REQ-005 SHALL have ports:
  wb_clk_i      in   1   clock
  wb_rst_i      in   1   synchronous active-high reset
  wbs_stb_i     in   1   Wishbone strobe
  wbs_cyc_i     in   1   Wishbone cycle
  wbs_we_i      in   1   write enable
  wbs_sel_i     in   4   byte select (ignored; full-word access only)
  wbs_dat_i     in   32  write data
  wbs_adr_i     in   32  address
  wbs_ack_o     out  1   acknowledge, one-cycle pulse
  wbs_dat_o     out  32  read data
  cfg_shift_en  out  1   shift chain advances one bit this cycle
  cfg_data      out  1   serial bit into chain, valid when cfg_shift_en=1
  cfg_latch_en  out  1   transfers chain contents to config latches
  cfg_done      out  1   configuration committed; FPGA fabric may run

Function
REQ-006 SHALL map registers by wbs_adr_i[3:2]: 0 DATA (W), 1 CTRL (W), 2 STATUS (R), 3 COUNT (R); reads of W-only regs return 0; writes to R-only regs are acked and ignored.
REQ-007 SHALL treat a request as stb&cyc&address hit; non-hitting requests are never acked.
REQ-008 SHALL assert wbs_ack_o for exactly one cycle, the cycle after the request is accepted, and never in the cycle immediately following its own ack.
REQ-009 SHALL accept reads immediately (ack latency 1); wbs_dat_o valid during ack, 0 otherwise.
REQ-010 SHALL accept DATA and CTRL writes only in state IDLE or DONE; in SHIFT or LATCH the ack is withheld (stall) until IDLE/DONE is reached.
REQ-011 SHALL implement states IDLE, SHIFT, LATCH, DONE.
REQ-012 DATA write in IDLE: load word into shift register, go to SHIFT next cycle.
REQ-013 SHIFT: each cycle cfg_shift_en=1, cfg_data=word bit, LSB first, COUNT+1; after 32 bits return to IDLE.
REQ-014 SHIFT SHALL stop early when COUNT reaches CHAIN_LEN; remaining word bits discarded, STATUS.ovf set, return to IDLE.
REQ-015 DATA write when COUNT==CHAIN_LEN SHALL be acked, shift nothing, set STATUS.ovf.
REQ-016 CTRL bit0 (clear): COUNT=0, ovf=0, err=0, cfg_done=0, state IDLE; takes priority over bit1 in the same write.
REQ-017 CTRL bit1 (commit): if COUNT==CHAIN_LEN go to LATCH; else set STATUS.err and stay.
REQ-018 LATCH: cfg_latch_en=1 for exactly LATCH_CYCLES cycles, then DONE.
REQ-019 DONE: cfg_done=1; DATA writes in DONE are treated as in IDLE after first clearing cfg_done (reconfiguration).
REQ-020 STATUS SHALL be {28'b0, err, ovf, done, busy}; busy=1 in SHIFT or LATCH.
REQ-021 COUNT SHALL read zero-extended bit count, saturating at CHAIN_LEN.
REQ-022 cfg_shift_en and cfg_latch_en SHALL never be high in the same cycle.

Reset
REQ-023 On wb_rst_i=1 at a clock edge: state IDLE, COUNT=0, flags 0, wbs_ack_o=0, wbs_dat_o=0, cfg_shift_en=0, cfg_data=0, cfg_latch_en=0, cfg_done=0.
REQ-024 Reset mid-SHIFT or mid-LATCH SHALL abort immediately; a pending Wishbone request is dropped without ack.

Verification
REQ-025 CHAIN_LEN=64: write DATA 0xA5A5_A5A5 then 0x0000_0001 -> 64 shift cycles, bit sequence LSB first, COUNT=64, ovf=0.
REQ-026 CHAIN_LEN=64 full, commit -> cfg_latch_en high 2 cycles, then cfg_done=1, STATUS=0x2.
REQ-027 CHAIN_LEN=40: two DATA writes -> only 8 bits of second word shifted, COUNT=40, STATUS.ovf=1.
REQ-028 Commit with COUNT=32 of 64 -> no latch pulse, STATUS.err=1, cfg_done=0.
REQ-029 Back-to-back DATA writes -> second ack withheld exactly until SHIFT ends; no ack for address outside BASE_ADDR.
REQ-030 Reset asserted at bit 10 of SHIFT -> next cycle all outputs 0, COUNT reads 0.

Source files
------------

// File: rtl/config_chain_sequencer.sv
// Wishbone-controlled sequencer that streams 32-bit words LSB-first into an FPGA
// configuration shift chain, then pulses the latch enable to commit the chain.
module config_chain_sequencer #(
  parameter int          CHAIN_LEN    = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          LATCH_CYCLES = 2
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cfg_shift_en,
  output logic        cfg_data,
  output logic        cfg_latch_en,
  output logic        cfg_done
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam logic [CW-1:0] FULL = CW'(CHAIN_LEN);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [4:0]    bit_idx, bit_idx_nxt;
  logic [3:0]    lat_cnt, lat_cnt_nxt;
  logic          ovf, ovf_nxt, err, err_nxt;
  logic [31:0]   shreg, shreg_nxt;
  logic          ack_p1, ack_nxt;
  logic [31:0]   dat_p1, dat_nxt;

  logic        hit, req, wr_cfg, idle_like, accept, full;
  logic [31:0] status;
  logic        unused_ok;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[1:0]};

  // A request seen in the cycle after our own ack is the same transfer still held.
  assign hit       = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req       = wbs_stb_i & wbs_cyc_i & hit & ~ack_p1;
  assign wr_cfg    = wbs_we_i & ~wbs_adr_i[3];
  assign idle_like = (state == IDLE) || (state == DONE);
  assign accept    = req & (~wr_cfg | idle_like);
  assign full      = (count == FULL);
  assign status    = {28'b0, err, ovf, (state == DONE), (state == SHIFT) || (state == LATCH)};

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    bit_idx_nxt = bit_idx;
    lat_cnt_nxt = lat_cnt;
    ovf_nxt     = ovf;
    err_nxt     = err;
    shreg_nxt   = shreg;
    ack_nxt     = accept;
    dat_nxt     = 32'b0;

    case (state)
      SHIFT: begin
        shreg_nxt   = shreg >> 1;
        count_nxt   = count + CW'(1);
        bit_idx_nxt = bit_idx + 5'd1;
        if ((count + CW'(1)) == FULL) begin
          state_nxt = IDLE;
          if (bit_idx != 5'd31) ovf_nxt = 1'b1;
        end else if (bit_idx == 5'd31) begin
          state_nxt = IDLE;
        end
      end
      LATCH: begin
        if (lat_cnt == 4'(LATCH_CYCLES - 1)) state_nxt = DONE;
        else lat_cnt_nxt = lat_cnt + 4'd1;
      end
      default: ;
    endcase

    // Config writes are only accepted in IDLE/DONE, so they never collide with the above.
    if (accept) begin
      if (!wbs_we_i) begin
        case (wbs_adr_i[3:2])
          2'd2:    dat_nxt = status;
          2'd3:    dat_nxt = 32'(count);
          default: dat_nxt = 32'b0;
        endcase
      end else if (wbs_adr_i[3:2] == 2'd0) begin
        if (full) begin
          ovf_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          shreg_nxt   = wbs_dat_i;
          bit_idx_nxt = 5'd0;
          state_nxt   = SHIFT;
        end
      end else if (wbs_adr_i[3:2] == 2'd1) begin
        if (wbs_dat_i[0]) begin
          count_nxt = '0;
          ovf_nxt   = 1'b0;
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end else if (wbs_dat_i[1]) begin
          if (full) begin
            state_nxt   = LATCH;
            lat_cnt_nxt = 4'd0;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      count   <= '0;
      bit_idx <= 5'd0;
      lat_cnt <= 4'd0;
      ovf     <= 1'b0;
      err     <= 1'b0;
      ack_p1  <= 1'b0;
      dat_p1  <= 32'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      bit_idx <= bit_idx_nxt;
      lat_cnt <= lat_cnt_nxt;
      ovf     <= ovf_nxt;
      err     <= err_nxt;
      ack_p1  <= ack_nxt;
      dat_p1  <= dat_nxt;
    end
  end

  // Shift data needs no reset: cfg_data is gated by the shift state.
  always_ff @(posedge wb_clk_i) begin
    shreg <= shreg_nxt;
  end

  assign wbs_ack_o    = ack_p1;
  assign wbs_dat_o    = dat_p1;
  assign cfg_shift_en = (state == SHIFT);
  assign cfg_data     = (state == SHIFT) & shreg[0];
  assign cfg_latch_en = (state == LATCH);
  assign cfg_done     = (state == DONE);

endmodule
